// File: rtl/arb_pkg.sv
// Shared types for the arbiter output buffering stage.
package arb_pkg;

    localparam int ARB_DW = 32;

    // MODE_IDLE is the arbiter's quiesce value; any other mode is a real beat.
    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_1    = 2'd1,
        MODE_2    = 2'd2,
        MODE_3    = 2'd3
    } arb_mode_t;

    // Field order here is the bit order used for each stored entry.
    typedef struct packed {
        arb_mode_t         mode;
        logic [7:0]        proc_val;
        logic [ARB_DW-1:0] data;
        logic              source;
    } arb_entry_t;

    localparam int ARB_ENTRY_W = $bits(arb_entry_t);

endpackage

// File: rtl/arb_fifo_mem.sv
// Entry storage for arb_out_fifo: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module arb_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int EW    = 43,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    logic [EW-1:0] mem [DEPTH];

    // Write port: store the packed entry at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/arb_out_fifo.sv
// First-word-fall-through buffer between the two-slave arbiter and the pixel
// engine. Optional per-source accept counters are enabled by defining
// ARB_FIFO_SRC_CNT_EN.
module arb_out_fifo
    import arb_pkg::*;
#(
    parameter int DW        = ARB_DW,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_valid,
    input  logic [1:0]                 wr_mode,
    input  logic [DW-1:0]              wr_data,
    input  logic [7:0]                 wr_proc_val,
    input  logic                       wr_source,
    output logic                       fifo_full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_err,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [1:0]                 rd_mode,
    output logic [DW-1:0]              rd_data,
    output logic [7:0]                 rd_proc_val,
    output logic                       rd_source
`ifdef ARB_FIFO_SRC_CNT_EN
    ,
    output logic [15:0]                src0_cnt,
    output logic [15:0]                src1_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 + 8 + DW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [EW-1:0] head;
    logic          beat;
    logic          has_room;
    logic          we;
    logic          re;

    // A beat is any non-idle write; idle beats are dropped without error.
    assign beat     = wr_valid && (arb_mode_t'(wr_mode) != MODE_IDLE);
    // Room is judged on registered occupancy only, never on a same-cycle read,
    // so fifo_full stays a pure decode of state.
    assign has_room = count_q < CW'(DEPTH);
    assign we       = beat && has_room && !flush;
    assign re       = rd_valid && rd_ready && !flush;

    arb_fifo_mem #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata ({wr_mode, wr_proc_val, wr_data, wr_source}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointer, occupancy and sticky overflow state; flush outranks traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_err <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (we) wr_ptr <= wr_ptr + AW'(1);
            if (re) rd_ptr <= rd_ptr + AW'(1);
            case ({we, re})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (beat && !has_room) ovf_err <= 1'b1;
        end
    end

    assign count       = count_q;
    assign fifo_full   = count_q == CW'(DEPTH);
    assign almost_full = count_q >= CW'(AF_THRESH);
    assign rd_valid    = count_q != '0;

    // Head fields fall through from storage and read as zero while empty.
    always_comb begin
        {rd_mode, rd_proc_val, rd_data, rd_source} = '0;
        if (rd_valid) begin
            {rd_mode, rd_proc_val, rd_data, rd_source} = head;
        end
    end

`ifdef ARB_FIFO_SRC_CNT_EN
    // Saturating per-source counts of accepted writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src0_cnt <= '0;
            src1_cnt <= '0;
        end else if (flush) begin
            src0_cnt <= '0;
            src1_cnt <= '0;
        end else if (we) begin
            if (!wr_source && src0_cnt != 16'hFFFF) src0_cnt <= src0_cnt + 16'd1;
            if (wr_source && src1_cnt != 16'hFFFF)  src1_cnt <= src1_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arb_out_fifo.sv
// Directed bench for arb_out_fifo: a vector table for basic ordering and
// simultaneous traffic, then hand sequences for fill/overflow, flush and reset.
module tb_arb_out_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        wr_valid;
    logic [1:0]  wr_mode;
    logic [31:0] wr_data;
    logic [7:0]  wr_proc_val;
    logic        wr_source;
    logic        fifo_full;
    logic        almost_full;
    logic [4:0]  count;
    logic        ovf_err;
    logic        rd_ready;
    logic        rd_valid;
    logic [1:0]  rd_mode;
    logic [31:0] rd_data;
    logic [7:0]  rd_proc_val;
    logic        rd_source;
`ifdef ARB_FIFO_SRC_CNT_EN
    logic [15:0] src0_cnt;
    logic [15:0] src1_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    arb_out_fifo #(.DW(32), .DEPTH(16), .AF_THRESH(14)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_mode     (wr_mode),
        .wr_data     (wr_data),
        .wr_proc_val (wr_proc_val),
        .wr_source   (wr_source),
        .fifo_full   (fifo_full),
        .almost_full (almost_full),
        .count       (count),
        .ovf_err     (ovf_err),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_mode     (rd_mode),
        .rd_data     (rd_data),
        .rd_proc_val (rd_proc_val),
        .rd_source   (rd_source)
`ifdef ARB_FIFO_SRC_CNT_EN
        ,
        .src0_cnt    (src0_cnt),
        .src1_cnt    (src1_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [1:0]  wm;
        logic [31:0] wd;
        logic        ws;
        logic        rr;
        int          ecnt;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  em;
        logic        es;
        logic        eovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic wv, logic [1:0] wm, logic [31:0] wd, logic ws, logic rr,
                                int ecnt, logic ev, logic [31:0] ed, logic [1:0] em,
                                logic es, logic eovf);
        vec_t v;
        v.wv = wv; v.wm = wm; v.wd = wd; v.ws = ws; v.rr = rr;
        v.ecnt = ecnt; v.ev = ev; v.ed = ed; v.em = em; v.es = es; v.eovf = eovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; wr_valid = 0; wr_mode = 0; wr_data = 0;
        wr_proc_val = 0; wr_source = 0; rd_ready = 0;
    endtask

    task automatic write_one(input logic [31:0] d, input logic src);
        wr_valid = 1; wr_mode = 2'd1; wr_data = d; wr_source = src; rd_ready = 0;
        step();
        wr_valid = 0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();

        // Vector table: ordering, idle-mode drop, simultaneous read/write.
        tbl.push_back(mk(1, 1, 32'hA0, 0, 0, 1, 1, 32'hA0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 32'hA1, 0, 0, 2, 1, 32'hA0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 32'hA2, 0, 0, 3, 1, 32'hA0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,  0, 1, 2, 1, 32'hA1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,  0, 1, 1, 1, 32'hA2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 32'h0,  0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h77, 0, 0, 0, 0, 32'h0,  0, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 2, 32'hB0 + i, 1, 0, i + 1, 1, 32'hB0, 2, 1, 0));
        tbl.push_back(mk(1, 2, 32'hB5, 1, 1, 5, 1, 32'hB1, 2, 1, 0));
        tbl.push_back(mk(1, 0, 32'hCC, 0, 0, 5, 1, 32'hB1, 2, 1, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(0, 0, 32'h0, 0, 1, 5 - i, (i < 5),
                             (i < 5) ? 32'hB1 + i : 32'h0, (i < 5) ? 2'd2 : 2'd0,
                             (i < 5), 0));

        #12;
        chk("reset_count", 32'(count), 0);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_full", 32'(fifo_full), 0);
        chk("reset_af", 32'(almost_full), 0);
        chk("reset_ovf", 32'(ovf_err), 0);
        rst_n = 1;

        foreach (tbl[i]) begin
            wr_valid = tbl[i].wv; wr_mode = tbl[i].wm; wr_data = tbl[i].wd;
            wr_source = tbl[i].ws; rd_ready = tbl[i].rr; wr_proc_val = 8'(i);
            step();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
            chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_rd_data", i), rd_data, tbl[i].ed);
            chk($sformatf("vec%0d_rd_mode", i), 32'(rd_mode), 32'(tbl[i].em));
            chk($sformatf("vec%0d_rd_source", i), 32'(rd_source), 32'(tbl[i].es));
            chk($sformatf("vec%0d_full", i), 32'(fifo_full), 32'(tbl[i].ecnt == 16));
            chk($sformatf("vec%0d_af", i), 32'(almost_full), 32'(tbl[i].ecnt >= 14));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf_err), 32'(tbl[i].eovf));
        end
        idle_inputs();

        // Fill to DEPTH and watch the threshold flags.
        for (int k = 1; k <= 16; k++) begin
            write_one(32'(k - 1), 1'(k));
            chk($sformatf("fill%0d_count", k), 32'(count), 32'(k));
            chk($sformatf("fill%0d_af", k), 32'(almost_full), 32'(k >= 14));
            chk($sformatf("fill%0d_full", k), 32'(fifo_full), 32'(k == 16));
        end
        chk("fill_head", rd_data, 32'h0);
        chk("fill_ovf_clean", 32'(ovf_err), 0);

        write_one(32'hDEAD, 0);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_flag", 32'(ovf_err), 1);
        chk("ovf_full", 32'(fifo_full), 1);

        // Read and write together while full: read only.
        wr_valid = 1; wr_mode = 2'd3; wr_data = 32'hBEEF; rd_ready = 1;
        step();
        idle_inputs();
        chk("full_rw_count", 32'(count), 15);
        chk("full_rw_full", 32'(fifo_full), 0);
        chk("full_rw_head", rd_data, 32'h1);
        chk("full_rw_ovf", 32'(ovf_err), 1);

        for (int k = 1; k <= 15; k++) begin
            chk($sformatf("drain%0d_data", k), rd_data, 32'(k));
            rd_ready = 1;
            step();
        end
        rd_ready = 0;
        chk("drain_count", 32'(count), 0);
        chk("drain_rd_valid", 32'(rd_valid), 0);

        // Flush with a concurrent write while overflow is still flagged.
        for (int k = 0; k < 9; k++) write_one(32'h100 + k, 0);
        chk("pre_flush_count", 32'(count), 9);
        chk("pre_flush_ovf", 32'(ovf_err), 1);
        flush = 1; wr_valid = 1; wr_mode = 2'd1; wr_data = 32'h99; rd_ready = 1;
        step();
        idle_inputs();
        chk("flush_count", 32'(count), 0);
        chk("flush_rd_valid", 32'(rd_valid), 0);
        chk("flush_ovf", 32'(ovf_err), 0);
        chk("flush_rd_data", rd_data, 0);
        write_one(32'h55, 0);
        chk("post_flush_head", rd_data, 32'h55);
        chk("post_flush_count", 32'(count), 1);
        rd_ready = 1;
        step();
        rd_ready = 0;
        chk("post_flush_empty", 32'(count), 0);

        // Asynchronous reset in the middle of traffic.
        write_one(32'h11, 0);
        write_one(32'h22, 1);
        #1;
        rst_n = 0;
        #1;
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_valid", 32'(rd_valid), 0);
        chk("async_rst_data", rd_data, 0);
        #2;
        rst_n = 1;

`ifdef ARB_FIFO_SRC_CNT_EN
        for (int k = 0; k < 4; k++) write_one(32'h200 + k, 0);
        for (int k = 0; k < 7; k++) write_one(32'h300 + k, 1);
        chk("src0_cnt", 32'(src0_cnt), 4);
        chk("src1_cnt", 32'(src1_cnt), 7);
        flush = 1;
        step();
        flush = 0;
        chk("src0_cnt_flush", 32'(src0_cnt), 0);
        chk("src1_cnt_flush", 32'(src1_cnt), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
